eth_rx_frame_check: RTL and testbench

//   Qualifies RGMII-receive frames (SDR byte + ctl, clk domain) before packet_rx.

---
 rtl/eth_rx_frame_check_pkg.sv | 32 +++
 rtl/eth_rx_frame_check_if.sv | 31 +++
 rtl/eth_rx_frame_check_crc32_d8.sv | 21 ++
 rtl/eth_rx_frame_check.sv | 176 +++++++++++++++++
 tb/tb_eth_rx_frame_check.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_rx_frame_check_pkg.sv
// Shared constants, types and helpers for the RGMII receive frame checker.
// CRC constants describe reflected CRC-32 (poly EDB88320), checked by residue.
package eth_rx_frame_check_pkg;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [7:0]  SFD         = 8'hD5;
  localparam logic [1:0]  CTL_VALID   = 2'b11;
  localparam logic [1:0]  CTL_ERR     = 2'b01;

  localparam int LEN_W = 11;
  localparam logic [LEN_W-1:0] LEN_SAT = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_BODY,
    ST_DROP
  } rx_state_e;

  typedef struct packed {
    logic phy_err;
    logic len_err;
    logic crc_err;
  } err_flags_t;

  function automatic logic [LEN_W-1:0] len_inc(input logic [LEN_W-1:0] l);
    return (l == LEN_SAT) ? l : l + LEN_W'(1);
  endfunction

endpackage

// File: rtl/eth_rx_frame_check_if.sv
// Receive byte stream, pass-through and verdict/statistics bundle of eth_rx_frame_check.
// slave = the checker, master = whatever feeds it and consumes its results.
interface eth_rx_frame_check_if #(parameter int CNT_W = 16);
  import eth_rx_frame_check_pkg::*;

  logic [7:0]       data_in;
  logic [1:0]       ctl_in;
  logic [7:0]       data_out;
  logic [1:0]       ctl_out;
  logic             frame_done;
  logic             frame_good;
  logic [LEN_W-1:0] frame_len;
  logic [2:0]       err_flags;
  logic [CNT_W-1:0] cnt_good;
  logic [CNT_W-1:0] cnt_crc;
  logic [CNT_W-1:0] cnt_len;
  logic [CNT_W-1:0] cnt_phy;

  modport master (
    output data_in, ctl_in,
    input  data_out, ctl_out, frame_done, frame_good, frame_len, err_flags,
    input  cnt_good, cnt_crc, cnt_len, cnt_phy
  );

  modport slave (
    input  data_in, ctl_in,
    output data_out, ctl_out, frame_done, frame_good, frame_len, err_flags,
    output cnt_good, cnt_crc, cnt_len, cnt_phy
  );

endinterface

// File: rtl/eth_rx_frame_check_crc32_d8.sv
// Combinational byte-wide CRC-32 step, reflected (LSB first); shared with the TX FCS generator.
module eth_rx_frame_check_crc32_d8
  import eth_rx_frame_check_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  d,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
      else             c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_rx_frame_check.sv
// RGMII receive frame qualifier: 1-clk pass-through plus per-frame CRC/length/PHY-error verdict.
// Define ETH_RX_STATS_EN to build the saturating good/crc/len/phy statistics counters.
module eth_rx_frame_check
  import eth_rx_frame_check_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic reset,
  eth_rx_frame_check_if.slave rx
);

  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  rx_state_e        state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic [1:0]       ctl_q, ctl_d;
  logic [31:0]      crc_q, crc_d, crc_next;
  logic [LEN_W-1:0] len_q, len_d;
  logic             phy_err_q, phy_err_d;
  logic             done_q, done_d;
  logic             good_q, good_d;
  logic [LEN_W-1:0] flen_q, flen_d;
  err_flags_t       flags_q, flags_d;
  logic             start_frame, hash_en, verdict_en;

  eth_rx_frame_check_crc32_d8 u_crc (
    .crc_in (crc_q),
    .d      (rx.data_in),
    .crc_out(crc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (rx.ctl_in[0]) state_d = ST_PRE;
      ST_PRE: begin
        if (!rx.ctl_in[0])                                state_d = ST_IDLE;
        else if (rx.ctl_in == CTL_ERR)                    state_d = ST_DROP;
        else if (rx.ctl_in == CTL_VALID && rx.data_in == SFD) state_d = ST_BODY;
      end
      ST_BODY: if (!rx.ctl_in[0]) state_d = ST_IDLE;
      ST_DROP: if (!rx.ctl_in[0]) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start_frame = (state_q == ST_PRE) && (rx.ctl_in == CTL_VALID) && (rx.data_in == SFD);
    hash_en     = (state_q == ST_BODY) && rx.ctl_in[0];
    verdict_en  = (state_q == ST_BODY) && !rx.ctl_in[0];
  end

  // Bytes flagged with a PHY error are still hashed and counted so frame_len stays honest.
  always_comb begin
    data_d    = rx.data_in;
    ctl_d     = rx.ctl_in;
    crc_d     = crc_q;
    len_d     = len_q;
    phy_err_d = phy_err_q;
    done_d    = 1'b0;
    good_d    = good_q;
    flen_d    = flen_q;
    flags_d   = flags_q;
    if (start_frame) begin
      crc_d     = CRC_INIT;
      len_d     = '0;
      phy_err_d = 1'b0;
    end
    if (hash_en) begin
      crc_d = crc_next;
      len_d = len_inc(len_q);
      if (rx.ctl_in == CTL_ERR) phy_err_d = 1'b1;
    end
    if (verdict_en) begin
      flags_d.crc_err = (crc_q != CRC_RESIDUE);
      flags_d.len_err = (len_q < MIN_L) || (len_q > MAX_L);
      flags_d.phy_err = phy_err_q;
      good_d          = ~(|flags_d);
      flen_d          = len_q;
      done_d          = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q    <= '0;
      ctl_q     <= '0;
      crc_q     <= CRC_INIT;
      len_q     <= '0;
      phy_err_q <= 1'b0;
      done_q    <= 1'b0;
      good_q    <= 1'b0;
      flen_q    <= '0;
      flags_q   <= '0;
    end else begin
      data_q    <= data_d;
      ctl_q     <= ctl_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      phy_err_q <= phy_err_d;
      done_q    <= done_d;
      good_q    <= good_d;
      flen_q    <= flen_d;
      flags_q   <= flags_d;
    end
  end

  assign rx.data_out   = data_q;
  assign rx.ctl_out    = ctl_q;
  assign rx.frame_done = done_q;
  assign rx.frame_good = good_q;
  assign rx.frame_len  = flen_q;
  assign rx.err_flags  = flags_q;

`ifdef ETH_RX_STATS_EN
  logic [CNT_W-1:0] cnt_good_q, cnt_good_d;
  logic [CNT_W-1:0] cnt_crc_q, cnt_crc_d;
  logic [CNT_W-1:0] cnt_len_q, cnt_len_d;
  logic [CNT_W-1:0] cnt_phy_q, cnt_phy_d;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // Counters move on the same edge as the verdict so they are current while frame_done is high.
  always_comb begin
    cnt_good_d = cnt_good_q;
    cnt_crc_d  = cnt_crc_q;
    cnt_len_d  = cnt_len_q;
    cnt_phy_d  = cnt_phy_q;
    if (done_d) begin
      if (good_d) begin
        cnt_good_d = cnt_inc(cnt_good_q);
      end else begin
        if (flags_d.crc_err) cnt_crc_d = cnt_inc(cnt_crc_q);
        if (flags_d.len_err) cnt_len_d = cnt_inc(cnt_len_q);
        if (flags_d.phy_err) cnt_phy_d = cnt_inc(cnt_phy_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_good_q <= '0;
      cnt_crc_q  <= '0;
      cnt_len_q  <= '0;
      cnt_phy_q  <= '0;
    end else begin
      cnt_good_q <= cnt_good_d;
      cnt_crc_q  <= cnt_crc_d;
      cnt_len_q  <= cnt_len_d;
      cnt_phy_q  <= cnt_phy_d;
    end
  end

  assign rx.cnt_good = cnt_good_q;
  assign rx.cnt_crc  = cnt_crc_q;
  assign rx.cnt_len  = cnt_len_q;
  assign rx.cnt_phy  = cnt_phy_q;
`else
  assign rx.cnt_good = {CNT_W{1'b0}};
  assign rx.cnt_crc  = {CNT_W{1'b0}};
  assign rx.cnt_len  = {CNT_W{1'b0}};
  assign rx.cnt_phy  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_eth_rx_frame_check.sv
// Randomized bench for eth_rx_frame_check: frame-level reference model plus 1-clk pass-through check.
// Statistics expectations follow ETH_RX_STATS_EN as defined for the build.
module tb_eth_rx_frame_check;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic        good;
    logic [10:0] len;
    logic [2:0]  flags;
  } verdict_t;

`ifdef ETH_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  eth_rx_frame_check_if #(.CNT_W(16)) tb_if();

  eth_rx_frame_check #(.MIN_LEN(64), .MAX_LEN(1518), .CNT_W(16)) dut (
    .clk  (clk),
    .reset(reset),
    .rx   (tb_if.slave)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_seen = 0;
  bit chk_en = 1'b0;
  verdict_t exp_q[$];
  int exp_cyc_q[$];
  verdict_t held = '0;
  int m_good = 0, m_crc = 0, m_len = 0, m_phy = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Reference CRC: whole-frame byte loop, byte folded into the register then 8 shifts.
  function automatic logic [31:0] crcBytes(input byte_q_t b);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic byte_q_t addFcs(input byte_q_t b);
    byte_q_t r = b;
    logic [31:0] f = ~crcBytes(b);
    for (int k = 0; k < 4; k++) r.push_back(f[8*k +: 8]);
    return r;
  endfunction

  function automatic byte_q_t randomFrame(input int n);
    byte_q_t r;
    for (int i = 0; i < n - 4; i++) r.push_back(8'($urandom));
    return addFcs(r);
  endfunction

  function automatic byte_q_t arpFrame();
    byte_q_t r;
    r = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33,
          8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
          8'h02, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'd192, 8'd168, 8'd1, 8'd10,
          8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'd192, 8'd168, 8'd1, 8'd1};
    while (r.size() < 60) r.push_back(8'h00);
    return addFcs(r);
  endfunction

  function automatic verdict_t modelVerdict(input byte_q_t frm, input bit phy);
    verdict_t v;
    int n = frm.size();
    bit crc_err = (crcBytes(frm) != 32'hDEBB_20E3);
    bit len_err = (n < 64) || (n > 1518);
    v.len   = 11'((n > 2047) ? 2047 : n);
    v.flags = {phy, len_err, crc_err};
    v.good  = !(phy || len_err || crc_err);
    return v;
  endfunction

  task automatic applyStimulus(input logic [7:0] d, input logic [1:0] c);
    @(negedge clk);
    tb_if.data_in = d;
    tb_if.ctl_in  = c;
  endtask

  task automatic sendFrame(input byte_q_t frm, input int pre_len, input int err_pos, input int gap);
    exp_q.push_back(modelVerdict(frm, (err_pos >= 0) && (err_pos < frm.size())));
    repeat (pre_len) applyStimulus(8'h55, 2'b11);
    applyStimulus(8'hD5, 2'b11);
    foreach (frm[i]) applyStimulus(frm[i], (i == err_pos) ? 2'b01 : 2'b11);
    applyStimulus(8'h00, 2'b00);
    exp_cyc_q.push_back(cyc + 1);
    repeat (gap - 1) applyStimulus(8'h00, 2'b00);
  endtask

  task automatic checkVerdict(input string tag, input logic good, input int len, input logic [2:0] flags);
    checkOutput({tag, "_good"}, 32'(tb_if.frame_good), 32'(good));
    checkOutput({tag, "_len"}, 32'(tb_if.frame_len), 32'(len));
    checkOutput({tag, "_flags"}, 32'(tb_if.err_flags), 32'(flags));
  endtask

  function automatic int satInc(input int m);
    return (m < 65535) ? m + 1 : m;
  endfunction

  always @(posedge clk) begin : monitor
    logic [7:0] sd;
    logic [1:0] sc;
    verdict_t v;
    int ec;
    cyc++;
    sd = tb_if.data_in;
    sc = tb_if.ctl_in;
    #1;
    if (reset) begin
      held = '0;
      m_good = 0; m_crc = 0; m_len = 0; m_phy = 0;
      checkOutput("data_out_rst", 32'(tb_if.data_out), 32'h0);
      checkOutput("ctl_out_rst", 32'(tb_if.ctl_out), 32'h0);
    end else begin
      checkOutput("data_out", 32'(tb_if.data_out), 32'(sd));
      checkOutput("ctl_out", 32'(tb_if.ctl_out), 32'(sc));
      if (tb_if.frame_done) begin
        done_seen++;
        if (chk_en) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_done", 32'(tb_if.frame_done), 32'h0);
          end else begin
            v  = exp_q.pop_front();
            ec = (exp_cyc_q.size() != 0) ? exp_cyc_q.pop_front() : -1;
            checkOutput("done_cycle", 32'(cyc), 32'(ec));
            held = v;
            if (v.good) m_good = satInc(m_good);
            else begin
              if (v.flags[0]) m_crc = satInc(m_crc);
              if (v.flags[1]) m_len = satInc(m_len);
              if (v.flags[2]) m_phy = satInc(m_phy);
            end
          end
        end
      end
      if (chk_en) begin
        checkOutput("frame_good", 32'(tb_if.frame_good), 32'(held.good));
        checkOutput("frame_len", 32'(tb_if.frame_len), 32'(held.len));
        checkOutput("err_flags", 32'(tb_if.err_flags), 32'(held.flags));
        checkOutput("cnt_good", 32'(tb_if.cnt_good), STATS ? 32'(m_good) : 32'h0);
        checkOutput("cnt_crc", 32'(tb_if.cnt_crc), STATS ? 32'(m_crc) : 32'h0);
        checkOutput("cnt_len", 32'(tb_if.cnt_len), STATS ? 32'(m_len) : 32'h0);
        checkOutput("cnt_phy", 32'(tb_if.cnt_phy), STATS ? 32'(m_phy) : 32'h0);
      end
    end
  end

  initial begin : main
    byte_q_t arp, f;
    int d0, n, kind, pos;
    tb_if.data_in = 8'h00;
    tb_if.ctl_in  = 2'b00;
    repeat (3) @(negedge clk);
    checkOutput("rst_done", 32'(tb_if.frame_done), 32'h0);
    checkVerdict("rst", 1'b0, 0, 3'b000);
    checkOutput("rst_cnt_good", 32'(tb_if.cnt_good), 32'h0);
    reset = 1'b0;
    chk_en = 1'b1;
    repeat (2) applyStimulus(8'h00, 2'b00);

    arp = arpFrame();
    sendFrame(arp, 7, -1, 4);
    checkVerdict("t1", 1'b1, 64, 3'b000);
    checkOutput("t1_cnt_good", 32'(tb_if.cnt_good), STATS ? 32'd1 : 32'd0);

    f = arp;
    f[20] = f[20] ^ 8'h01;
    sendFrame(f, 7, -1, 4);
    checkVerdict("t2", 1'b0, 64, 3'b001);
    checkOutput("t2_cnt_crc", 32'(tb_if.cnt_crc), STATS ? 32'd1 : 32'd0);

    sendFrame(arp, 7, 30, 4);
    checkVerdict("t3", 1'b0, 64, 3'b100);
    checkOutput("t3_cnt_phy", 32'(tb_if.cnt_phy), STATS ? 32'd1 : 32'd0);

    sendFrame(randomFrame(40), 7, -1, 4);
    checkVerdict("t4_short", 1'b0, 40, 3'b010);
    sendFrame(randomFrame(1519), 7, -1, 4);
    checkVerdict("t4_long", 1'b0, 1519, 3'b010);
    sendFrame(randomFrame(2100), 7, -1, 4);
    checkVerdict("t4_sat", 1'b0, 2047, 3'b010);

    d0 = done_seen;
    repeat (7) applyStimulus(8'h55, 2'b11);
    applyStimulus(8'hD5, 2'b11);
    for (int i = 0; i < 25; i++) applyStimulus(arp[i], 2'b11);
    @(negedge clk);
    reset = 1'b1;
    tb_if.data_in = 8'h00;
    tb_if.ctl_in  = 2'b00;
    @(negedge clk);
    checkVerdict("t5_rst", 1'b0, 0, 3'b000);
    checkOutput("t5_rst_cnt_len", 32'(tb_if.cnt_len), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) applyStimulus(8'h00, 2'b00);
    checkOutput("t5_no_done", 32'(done_seen - d0), 32'h0);
    sendFrame(arp, 7, -1, 4);
    checkOutput("t5_done", 32'(done_seen - d0), 32'd1);
    checkVerdict("t5", 1'b1, 64, 3'b000);

    chk_en = 1'b0;
    repeat (300) applyStimulus(8'($urandom), 2'($urandom));
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tb_if.data_in = 8'h00;
    tb_if.ctl_in  = 2'b00;
    chk_en = 1'b1;
    applyStimulus(8'h00, 2'b00);

    d0 = done_seen;
    sendFrame(randomFrame(64), 7, -1, 1);
    sendFrame(randomFrame(80), 3, -1, 3);
    checkOutput("b2b_done", 32'(done_seen - d0), 32'd2);

    for (int k = 0; k < 25; k++) begin
      n    = int'($urandom_range(30, 140));
      f    = randomFrame(n);
      kind = int'($urandom_range(0, 3));
      pos  = -1;
      if (kind == 1 || kind == 3) begin
        int p = int'($urandom_range(0, n - 1));
        f[p] = f[p] ^ (8'h01 << $urandom_range(0, 7));
      end
      if (kind >= 2) pos = int'($urandom_range(0, n - 1));
      sendFrame(f, int'($urandom_range(1, 7)), pos, int'($urandom_range(1, 3)));
    end

    repeat (6) applyStimulus(8'h00, 2'b00);
    checkOutput("pending", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
